// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the Dino game blocks.
//   gs_state_e : game phase encoding, visible on game_sequencer's state output
//   BCD_DIGITS : number of decimal digits in the score
//   SCORE_W    : packed BCD score width (4 bits per digit)
// -----------------------------------------------------------------------------
package dino_pkg;

   typedef enum logic [1:0] {
      GS_IDLE      = 2'd0,
      GS_RUN       = 2'd1,
      GS_OVER_HOLD = 2'd2,
      GS_OVER      = 2'd3
   } gs_state_e;

   localparam int BCD_DIGITS = 4;
   localparam int SCORE_W    = 16;

endpackage

// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Bundles the game sequencer's event inputs and status outputs.
//   game_tick, game_start_pulse, game_over_pulse : one-clk event strobes
//   state, running, score, hi_score, new_hi, speed, obs_step : status
// Modports:
//   master : the side producing the event strobes and observing status
//   slave  : the game sequencer itself
// Event semantics: there is no backpressure. Every strobe is a single-cycle
// pulse sampled on exactly one rising clk edge; holding a strobe high for N
// cycles means N separate events.
// -----------------------------------------------------------------------------
interface game_sequencer_if;
   import dino_pkg::*;

   logic               game_tick;
   logic               game_start_pulse;
   logic               game_over_pulse;
   logic [1:0]         state;
   logic               running;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hi_score;
   logic               new_hi;
   logic [2:0]         speed;
   logic               obs_step;

   modport master (
      output game_tick, game_start_pulse, game_over_pulse,
      input  state, running, score, hi_score, new_hi, speed, obs_step
   );

   modport slave (
      input  game_tick, game_start_pulse, game_over_pulse,
      output state, running, score, hi_score, new_hi, speed, obs_step
   );

endinterface

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit packed BCD counter, saturating at 9999.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : increment by one
//   value_o      : packed BCD value, digit 3 in [15:12]
//   hund_roll_o  : registered one-cycle flag, high in the cycle after an
//                  increment whose result ends in 00 (every 100 points)
// -----------------------------------------------------------------------------
module bcd_counter4
   import dino_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [SCORE_W-1:0] value_o,
   output logic               hund_roll_o
);

   logic [SCORE_W-1:0] value_q;
   logic [SCORE_W-1:0] value_d;
   logic               roll_q;
   logic               at_max;

   assign at_max = (value_q == {BCD_DIGITS{4'h9}});

   // Ripple a +1 through the digits: a 9 wraps to 0 and keeps the carry going.
   always_comb begin : bcd_inc
      logic carry;
      value_d = value_q;
      carry   = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (carry) begin
            if (value_q[4*i +: 4] == 4'h9) begin
               value_d[4*i +: 4] = 4'h0;
            end else begin
               value_d[4*i +: 4] = value_q[4*i +: 4] + 4'h1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         roll_q  <= 1'b0;
      end else if (clr_i) begin
         value_q <= '0;
         roll_q  <= 1'b0;
      end else if (inc_i && !at_max) begin
         value_q <= value_d;
         roll_q  <= (value_d[7:0] == 8'h00);
      end else begin
         roll_q  <= 1'b0;
      end
   end

   assign value_o     = value_q;
   assign hund_roll_o = roll_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Central game-phase controller: IDLE / RUN / OVER_HOLD / OVER, score and
// high score, obstacle speed ramp and the per-frame obstacle step strobe.
// Parameters:
//   SCORE_DIV : game ticks per score increment
//   MAX_SPEED : speed saturation level (1..7)
//   OVER_HOLD : game ticks spent in OVER_HOLD before a restart is accepted
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : game_sequencer_if.slave (event strobes in, status out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module game_sequencer
   import dino_pkg::*;
#(
   parameter int SCORE_DIV = 6,
   parameter int MAX_SPEED = 4,
   parameter int OVER_HOLD = 60
) (
   input  logic             clk,
   input  logic             rst_n,
   game_sequencer_if.slave  bus
);

   localparam int DIV_W  = $clog2(SCORE_DIV + 1);
   localparam int HOLD_W = $clog2(OVER_HOLD + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(OVER_HOLD - 1);
   localparam logic [2:0]        SPEED_MAX = 3'(MAX_SPEED);

   gs_state_e          state_q;
   logic               running_q;
   logic [DIV_W-1:0]   div_q;
   logic [HOLD_W-1:0]  hold_q;
   logic [2:0]         speed_q;
   logic               new_hi_q;
   logic [SCORE_W-1:0] hi_score_q;
   logic               obs_step_q;

   logic               score_clr;
   logic               score_inc;
   logic [SCORE_W-1:0] score_w;
   logic               hund_roll;

   // Entering RUN clears the score in the same edge as the state change.
   assign score_clr = ((state_q == GS_IDLE) || (state_q == GS_OVER)) && bus.game_start_pulse;

   // A crash in the same cycle as a tick swallows that tick's increment.
   assign score_inc = (state_q == GS_RUN) && bus.game_tick && !bus.game_over_pulse &&
                      (div_q == DIV_LAST);

   bcd_counter4 u_score (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (score_clr),
      .inc_i       (score_inc),
      .value_o     (score_w),
      .hund_roll_o (hund_roll)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= GS_IDLE;
         running_q  <= 1'b0;
         div_q      <= '0;
         hold_q     <= '0;
         speed_q    <= 3'd0;
         new_hi_q   <= 1'b0;
         hi_score_q <= '0;
         obs_step_q <= 1'b0;
      end else begin
         obs_step_q <= 1'b0;

         // The hundreds flag lags the score by one clk, so the speed seen
         // alongside obs_step is still the pre-update value.
         if ((state_q == GS_RUN) && hund_roll && (speed_q < SPEED_MAX)) begin
            speed_q <= speed_q + 3'd1;
         end

         case (state_q)
            GS_IDLE, GS_OVER: begin
               // A tick arriving with the start pulse is discarded.
               if (bus.game_start_pulse) begin
                  state_q   <= GS_RUN;
                  running_q <= 1'b1;
                  div_q     <= '0;
                  speed_q   <= 3'd1;
                  new_hi_q  <= 1'b0;
               end
            end

            GS_RUN: begin
               if (bus.game_over_pulse) begin
                  state_q   <= GS_OVER_HOLD;
                  running_q <= 1'b0;
                  hold_q    <= HOLD_INIT;
                  // Packed BCD orders the same as plain unsigned binary.
                  if (score_w > hi_score_q) begin
                     hi_score_q <= score_w;
                     new_hi_q   <= 1'b1;
                  end
               end else if (bus.game_tick) begin
                  obs_step_q <= 1'b1;
                  div_q      <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
               end
            end

            GS_OVER_HOLD: begin
               if (bus.game_tick) begin
                  if (hold_q == '0) begin
                     state_q <= GS_OVER;
                  end else begin
                     hold_q <= hold_q - HOLD_W'(1);
                  end
               end
            end

            default: state_q <= GS_IDLE;
         endcase
      end
   end

   assign bus.state    = state_q;
   assign bus.running  = running_q;
   assign bus.score    = score_w;
   assign bus.hi_score = hi_score_q;
   assign bus.new_hi   = new_hi_q;
   assign bus.speed    = speed_q;
   assign bus.obs_step = obs_step_q;

endmodule
